if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 105 ++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues word fetches to instruction
// memory and feeds the IF/ID register. A one-entry skid buffer absorbs a word
// that arrives while decode is stalled, so no fetch is ever lost or repeated.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic        id_valid_o
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] skid_instr;
    logic [31:0] redirect_target;
    logic        fetch_done;

    // The memory address is the PC itself; the PC only advances once its
    // word has been handed to decode, so the skid word's PC is always pc.
    assign imem_addr       = pc;
    assign redirect_target = redirect_pc_i & 32'hFFFF_FFFC;
    // An ack only counts while a request is actually outstanding.
    assign fetch_done      = imem_req & imem_ack;

    // Fetch FSM with registered request, PC and IF/ID register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            imem_req   <= 1'b0;
            pc         <= RESET_PC;
            id_instr_o <= NOP_INSTR;
            id_pc_o    <= 32'h0000_0000;
            id_valid_o <= 1'b0;
        end else if (redirect_i) begin
            // Kill whatever is in IF/ID or the skid buffer and refetch.
            state      <= FETCH;
            imem_req   <= 1'b1;
            pc         <= redirect_target;
            id_instr_o <= NOP_INSTR;
            id_valid_o <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (stall_i) begin
                        if (fetch_done) begin
                            // Park the word; stop requesting until decode frees up.
                            state    <= HOLD;
                            imem_req <= 1'b0;
                        end else begin
                            imem_req <= 1'b1;
                        end
                    end else if (fetch_done) begin
                        id_instr_o <= imem_rdata;
                        id_pc_o    <= pc;
                        id_valid_o <= 1'b1;
                        pc         <= pc + 32'd4;
                        imem_req   <= 1'b1;
                    end else begin
                        // No word this cycle: send a bubble, keep the old PC tag.
                        id_instr_o <= NOP_INSTR;
                        id_valid_o <= 1'b0;
                        imem_req   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        id_instr_o <= skid_instr;
                        id_pc_o    <= pc;
                        id_valid_o <= 1'b1;
                        pc         <= pc + 32'd4;
                        state      <= FETCH;
                        imem_req   <= 1'b1;
                    end
                end
                default: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
            endcase
        end
    end

    // Skid buffer data: captured on a stalled fetch, validity is the HOLD state.
    always_ff @(posedge clk) begin
        if (!redirect_i && state == FETCH && stall_i && fetch_done) begin
            skid_instr <= imem_rdata;
        end
    end

endmodule
